// File: rtl/ped_crossing_unit.sv
// ---------------------------------------------------------------------------
// ped_crossing_unit
//
// Pedestrian crossing controller for one crosswalk. A raw push-button is
// synchronised and debounced into a single press event. The press raises a
// crossing request towards the intersection controller. The controller's
// walk grant runs a timed WALK phase, then a flashing DON'T WALK clearance
// phase.
//
// Ports
//   clk          in   1  clock, rising edge
//   reset        in   1  synchronous, active-high reset
//   btn_raw      in   1  raw asynchronous bouncing push-button
//   ped_sat      in   1  walk grant from intersection controller (1 = walk)
//   ped_req      out  1  crossing request pending
//   walk_lamp    out  1  steady WALK lamp
//   dwalk_lamp   out  1  DON'T WALK lamp (steady, or flashing in clearance)
//   req_ack_led  out  1  "request registered" indicator on the button
//   countdown    out  8  cycles remaining in WALK / FLASH, 0 otherwise
//   req_timeout  out  1  one-cycle pulse each REQ_TIMEOUT cycles without grant
// ---------------------------------------------------------------------------
module ped_crossing_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WALK_CYCLES     = 20,
    parameter int unsigned FLASH_CYCLES    = 10,
    parameter int unsigned FLASH_HALF      = 2,
    parameter int unsigned REQ_TIMEOUT     = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       ped_sat,
    output logic       ped_req,
    output logic       walk_lamp,
    output logic       dwalk_lamp,
    output logic       req_ack_led,
    output logic [7:0] countdown,
    output logic       req_timeout
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned FH_W = $clog2(FLASH_HALF + 1);
    localparam int unsigned WT_W = $clog2(REQ_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUESTED,
        ST_WALK,
        ST_FLASH
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: 2-flop synchroniser, then a debouncer that only
    // accepts a new level after it has been seen on DEBOUNCE_CYCLES edges
    // in a row.
    // ------------------------------------------------------------------
    logic [1:0]      sync_q;
    logic            btn_s;
    logic            btn_db_q;
    logic            btn_db_prev_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            ped_sat_prev_q;
    logic            press;
    logic            grant;

    assign btn_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q         <= 2'b00;
            btn_db_q       <= 1'b0;
            btn_db_prev_q  <= 1'b0;
            db_cnt_q       <= '0;
            ped_sat_prev_q <= 1'b0;
        end else begin
            sync_q         <= {sync_q[0], btn_raw};
            btn_db_prev_q  <= btn_db_q;
            ped_sat_prev_q <= ped_sat;
            if (btn_s == btn_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_q <= btn_s;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level: one event per physical press.
    assign press = btn_db_q & ~btn_db_prev_q;
    // History clears on reset, so ped_sat held high through reset release
    // is seen as a fresh grant.
    assign grant = ped_sat & ~ped_sat_prev_q;

    // ------------------------------------------------------------------
    // Crossing FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [7:0]      countdown_q, countdown_d;
    logic            walk_q, walk_d;
    logic            dwalk_q, dwalk_d;
    logic            ped_req_q, ped_req_d;
    logic            ack_q, ack_d;
    logic            timeout_q, timeout_d;
    logic [WT_W-1:0] wait_q, wait_d;
    logic [FH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic            pending_q, pending_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            countdown_q <= 8'd0;
            walk_q      <= 1'b0;
            dwalk_q     <= 1'b1;
            ped_req_q   <= 1'b0;
            ack_q       <= 1'b0;
            timeout_q   <= 1'b0;
            wait_q      <= '0;
            flash_cnt_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            countdown_q <= countdown_d;
            walk_q      <= walk_d;
            dwalk_q     <= dwalk_d;
            ped_req_q   <= ped_req_d;
            ack_q       <= ack_d;
            timeout_q   <= timeout_d;
            wait_q      <= wait_d;
            flash_cnt_q <= flash_cnt_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        walk_d      = walk_q;
        dwalk_d     = dwalk_q;
        ped_req_d   = ped_req_q;
        ack_d       = ack_q;
        timeout_d   = 1'b0;
        wait_d      = wait_q;
        flash_cnt_d = flash_cnt_q;
        pending_d   = pending_q;

        // Transitions and in-state housekeeping.
        case (state_q)
            ST_IDLE: begin
                // Grant beats a simultaneous press; the press is dropped.
                if (grant) begin
                    state_d = ST_WALK;
                end else if (press) begin
                    state_d = ST_REQUESTED;
                end
            end
            ST_REQUESTED: begin
                if (grant) begin
                    state_d = ST_WALK;
                end else if (wait_q == WT_W'(REQ_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    wait_d    = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WALK: begin
                // Grant withdrawn cuts WALK short into clearance.
                if (countdown_q == 8'd0 || !ped_sat) begin
                    state_d = ST_FLASH;
                end else begin
                    countdown_d = countdown_q - 8'd1;
                end
            end
            ST_FLASH: begin
                if (press) begin
                    pending_d = 1'b1;
                    ack_d     = 1'b1;
                end
                if (countdown_q == 8'd0) begin
                    state_d = pending_d ? ST_REQUESTED : ST_IDLE;
                end else begin
                    countdown_d = countdown_q - 8'd1;
                    if (flash_cnt_q == FH_W'(FLASH_HALF - 1)) begin
                        flash_cnt_d = '0;
                        dwalk_d     = ~dwalk_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entry values for the state being entered.
        if (state_d != state_q) begin
            pending_d = 1'b0;
            case (state_d)
                ST_IDLE: begin
                    ped_req_d   = 1'b0;
                    walk_d      = 1'b0;
                    dwalk_d     = 1'b1;
                    ack_d       = 1'b0;
                    countdown_d = 8'd0;
                end
                ST_REQUESTED: begin
                    ped_req_d   = 1'b1;
                    ack_d       = 1'b1;
                    walk_d      = 1'b0;
                    dwalk_d     = 1'b1;
                    countdown_d = 8'd0;
                    wait_d      = '0;
                end
                ST_WALK: begin
                    ped_req_d   = 1'b0;
                    ack_d       = 1'b0;
                    walk_d      = 1'b1;
                    dwalk_d     = 1'b0;
                    countdown_d = 8'(WALK_CYCLES - 1);
                end
                ST_FLASH: begin
                    ped_req_d   = 1'b0;
                    ack_d       = 1'b0;
                    walk_d      = 1'b0;
                    dwalk_d     = 1'b1;
                    countdown_d = 8'(FLASH_CYCLES - 1);
                    flash_cnt_d = '0;
                end
                default: ;
            endcase
        end
    end

    assign ped_req     = ped_req_q;
    assign walk_lamp   = walk_q;
    assign dwalk_lamp  = dwalk_q;
    assign req_ack_led = ack_q;
    assign countdown   = countdown_q;
    assign req_timeout = timeout_q;

endmodule
